// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers: route-source constants and a constant-foldable clog2.
package axis_pkg;

  localparam int ROUTE_SELECT = 0;
  localparam int ROUTE_TDEST  = 1;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_demux_skid.sv
// Two-entry skid FIFO for one demux output; the head register drives the lane and holds its
// last payload while empty.
module axis_demux_skid #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_not_full,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_head_valid;
  logic             r_spare_valid;
  logic [WIDTH-1:0] r_head_data;
  logic [WIDTH-1:0] r_spare_data;

  logic             w_head_valid;
  logic             w_spare_valid;
  logic [WIDTH-1:0] w_head_data;
  logic [WIDTH-1:0] w_spare_data;
  logic             w_pop;

  assign w_pop = r_head_valid && i_ready;

  always_comb begin
    w_head_valid  = r_head_valid;
    w_spare_valid = r_spare_valid;
    w_head_data   = r_head_data;
    w_spare_data  = r_spare_data;
    if (w_pop || !r_head_valid) begin
      // Head is free this cycle: refill from the spare entry first to keep order.
      if (r_spare_valid) begin
        w_head_valid  = 1'b1;
        w_head_data   = r_spare_data;
        w_spare_valid = i_valid;
        if (i_valid) w_spare_data = i_data;
      end else begin
        w_head_valid = i_valid;
        if (i_valid) w_head_data = i_data;
      end
    end else if (i_valid) begin
      w_spare_valid = 1'b1;
      w_spare_data  = i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head_valid  <= 1'b0;
      r_spare_valid <= 1'b0;
      r_head_data   <= '0;
      r_spare_data  <= '0;
    end else begin
      r_head_valid  <= w_head_valid;
      r_spare_valid <= w_spare_valid;
      r_head_data   <= w_head_data;
      r_spare_data  <= w_spare_data;
    end
  end

  // Full only when both entries hold data; purely registered.
  assign o_not_full = !r_spare_valid;
  assign o_valid    = r_head_valid;
  assign o_data     = r_head_data;

endmodule

// File: rtl/axis_demux_route.sv
// Frame-aware 1-to-M_COUNT AXI-Stream demux with per-output skid buffers, out-of-range
// drop and saturating frame/drop statistics.
module axis_demux_route
  import axis_pkg::*;
#(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter bit ID_ENABLE   = 1'b0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_WIDTH  = 8,
  parameter bit USER_ENABLE = 1'b1,
  parameter int USER_WIDTH  = 1,
  parameter int ROUTE_MODE  = ROUTE_SELECT,
  parameter int CNT_WIDTH   = 16,
  localparam int CL_M_COUNT = clog2(M_COUNT)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]            s_axis_tkeep,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  input  logic [ID_WIDTH-1:0]              s_axis_tid,
  input  logic [DEST_WIDTH-1:0]            s_axis_tdest,
  input  logic [USER_WIDTH-1:0]            s_axis_tuser,
  output logic [M_COUNT*DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0]    m_axis_tkeep,
  output logic [M_COUNT-1:0]               m_axis_tvalid,
  input  logic [M_COUNT-1:0]               m_axis_tready,
  output logic [M_COUNT-1:0]               m_axis_tlast,
  output logic [M_COUNT*ID_WIDTH-1:0]      m_axis_tid,
  output logic [M_COUNT*DEST_WIDTH-1:0]    m_axis_tdest,
  output logic [M_COUNT*USER_WIDTH-1:0]    m_axis_tuser,
  input  logic                             enable,
  input  logic                             drop,
  input  logic [CL_M_COUNT-1:0]            select,
  output logic [CNT_WIDTH-1:0]             stat_frames,
  output logic [CNT_WIDTH-1:0]             stat_drops,
  output logic                             stat_drop_pulse,
  output logic                             stat_busy
);

  localparam int OFF_KEEP = DATA_WIDTH;
  localparam int OFF_ID   = OFF_KEEP + KEEP_WIDTH;
  localparam int OFF_DEST = OFF_ID + ID_WIDTH;
  localparam int OFF_USER = OFF_DEST + DEST_WIDTH;
  localparam int OFF_LAST = OFF_USER + USER_WIDTH;
  localparam int PW       = OFF_LAST + 1;
  localparam int N_SLOT   = 1 << CL_M_COUNT;

  localparam logic [CL_M_COUNT:0] M_COUNT_W = (CL_M_COUNT + 1)'(M_COUNT);

  logic                  r_frame;
  logic                  r_drop;
  logic [CL_M_COUNT-1:0] r_route;
  logic [CNT_WIDTH-1:0]  r_frames;
  logic [CNT_WIDTH-1:0]  r_drops;
  logic                  r_drop_pulse;

  logic [CL_M_COUNT-1:0] w_route;
  logic                  w_route_bad;
  logic                  w_drop;
  logic                  w_ready;
  logic                  w_accept;
  logic [M_COUNT-1:0]    w_not_full;
  logic [M_COUNT-1:0]    w_push;
  logic [N_SLOT-1:0]     w_not_full_slot;
  logic [KEEP_WIDTH-1:0] w_keep;
  logic [ID_WIDTH-1:0]   w_id;
  logic [USER_WIDTH-1:0] w_user;
  logic [PW-1:0]         w_payload;
  logic [PW-1:0]         w_lane_data [M_COUNT];
  logic                  w_unused;

  // Mid-frame the latched route/drop win; at frame start they come straight from the inputs.
  always_comb begin
    w_route     = r_route;
    w_drop      = r_drop;
    w_route_bad = 1'b0;
    if (!r_frame) begin
      w_route     = (ROUTE_MODE == ROUTE_TDEST) ? s_axis_tdest[CL_M_COUNT-1:0] : select;
      w_route_bad = {1'b0, w_route} >= M_COUNT_W;
      w_drop      = drop || w_route_bad;
    end
  end

  // Pad to a power of two so an out-of-range route indexes a defined zero.
  always_comb begin
    w_not_full_slot              = '0;
    w_not_full_slot[M_COUNT-1:0] = w_not_full;
  end

  assign w_ready       = enable && !rst && (w_drop || w_not_full_slot[w_route]);
  assign w_accept      = s_axis_tvalid && w_ready;
  assign s_axis_tready = w_ready;

  assign w_keep    = KEEP_ENABLE ? s_axis_tkeep : '1;
  assign w_id      = ID_ENABLE ? s_axis_tid : '0;
  assign w_user    = USER_ENABLE ? s_axis_tuser : '0;
  assign w_payload = {s_axis_tlast, w_user, s_axis_tdest, w_id, w_keep, s_axis_tdata};

  for (genvar k = 0; k < M_COUNT; k++) begin : g_lane
    assign w_push[k] = w_accept && !w_drop && (w_route == CL_M_COUNT'(k));

    axis_demux_skid #(
      .WIDTH(PW)
    ) u_skid (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_valid   (w_push[k]),
      .i_data    (w_payload),
      .o_not_full(w_not_full[k]),
      .o_valid   (m_axis_tvalid[k]),
      .i_ready   (m_axis_tready[k]),
      .o_data    (w_lane_data[k])
    );

    assign m_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH] = w_lane_data[k][0 +: DATA_WIDTH];
    assign m_axis_tkeep[k*KEEP_WIDTH +: KEEP_WIDTH] = w_lane_data[k][OFF_KEEP +: KEEP_WIDTH];
    assign m_axis_tid[k*ID_WIDTH +: ID_WIDTH]       = w_lane_data[k][OFF_ID +: ID_WIDTH];
    assign m_axis_tdest[k*DEST_WIDTH +: DEST_WIDTH] = w_lane_data[k][OFF_DEST +: DEST_WIDTH];
    assign m_axis_tuser[k*USER_WIDTH +: USER_WIDTH] = w_lane_data[k][OFF_USER +: USER_WIDTH];
    assign m_axis_tlast[k]                          = w_lane_data[k][OFF_LAST];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame      <= 1'b0;
      r_route      <= '0;
      r_drop       <= 1'b0;
      r_frames     <= '0;
      r_drops      <= '0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_drop_pulse <= 1'b0;
      if (w_accept) begin
        r_frame <= !s_axis_tlast;
        r_route <= w_route;
        r_drop  <= w_drop;
        if (!r_frame && w_drop) begin
          r_drop_pulse <= 1'b1;
          if (r_drops != '1) r_drops <= r_drops + CNT_WIDTH'(1);
        end
        if (s_axis_tlast && !w_drop && (r_frames != '1)) begin
          r_frames <= r_frames + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign stat_frames     = r_frames;
  assign stat_drops      = r_drops;
  assign stat_drop_pulse = r_drop_pulse;
  assign stat_busy       = r_frame;

  // Inputs that some parameter settings leave without a consumer.
  assign w_unused = ^{s_axis_tkeep, s_axis_tid, s_axis_tuser, s_axis_tdest, select, w_route_bad};

endmodule

// File: tb/tb_axis_demux_route.sv
// Bench for axis_demux_route (tdest routing, 3 outputs, 4-bit stats) against a queue model.
module tb_axis_demux_route;

  localparam int M = 3;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [7:0] de;
    logic       u;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tkeep;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [7:0]  s_tid;
  logic [7:0]  s_tdest;
  logic        s_tuser;
  logic [23:0] m_tdata;
  logic [2:0]  m_tkeep;
  logic [2:0]  m_tvalid;
  logic [2:0]  m_tready;
  logic [2:0]  m_tlast;
  logic [23:0] m_tid;
  logic [23:0] m_tdest;
  logic [2:0]  m_tuser;
  logic        enable;
  logic        drop;
  logic [1:0]  select;
  logic [3:0]  stat_frames;
  logic [3:0]  stat_drops;
  logic        stat_drop_pulse;
  logic        stat_busy;

  int         n_vec = 0;
  int         n_err = 0;
  int         n_pulse = 0;
  int         frames_exp = 0;
  int         drops_exp = 0;
  int         pulses_exp = 0;
  bit         rdy_rand = 1'b0;
  bit         en_rand = 1'b0;
  logic [2:0] rdy_fixed = 3'b111;
  beat_t      expq [M][$];

  always #5 clk = ~clk;

  axis_demux_route #(
    .M_COUNT   (3),
    .DATA_WIDTH(8),
    .ROUTE_MODE(1),
    .CNT_WIDTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_tdata),
    .s_axis_tkeep   (s_tkeep),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .s_axis_tlast   (s_tlast),
    .s_axis_tid     (s_tid),
    .s_axis_tdest   (s_tdest),
    .s_axis_tuser   (s_tuser),
    .m_axis_tdata   (m_tdata),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tlast   (m_tlast),
    .m_axis_tid     (m_tid),
    .m_axis_tdest   (m_tdest),
    .m_axis_tuser   (m_tuser),
    .enable         (enable),
    .drop           (drop),
    .select         (select),
    .stat_frames    (stat_frames),
    .stat_drops     (stat_drops),
    .stat_drop_pulse(stat_drop_pulse),
    .stat_busy      (stat_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Output monitor: every valid lane head must match the oldest beat expected on that lane.
  beat_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      chk("tready_in_reset", 32'(s_tready), 0);
    end else begin
      if (!enable) chk("tready_gated", 32'(s_tready), 0);
      if (stat_drop_pulse) n_pulse++;
      for (int k = 0; k < M; k++) begin
        if (m_tvalid[k]) begin
          chk("lane_has_expected", 32'(expq[k].size() > 0), 1);
          if (expq[k].size() > 0) begin
            mon_e = expq[k][0];
            chk("tdata", 32'(m_tdata[k*8 +: 8]), 32'(mon_e.d));
            chk("tlast", 32'(m_tlast[k]), 32'(mon_e.l));
            chk("tdest", 32'(m_tdest[k*8 +: 8]), 32'(mon_e.de));
            chk("tuser", 32'(m_tuser[k]), 32'(mon_e.u));
            chk("tkeep", 32'(m_tkeep[k]), 1);
            chk("tid", 32'(m_tid[k*8 +: 8]), 0);
            if (m_tready[k]) void'(expq[k].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    m_tready = rdy_rand ? 3'($urandom) : rdy_fixed;
    enable   = en_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input logic [7:0] de,
                           input logic u, input logic dr, input bit first, input int rt,
                           input bit dx, input int budget, output bit ok);
    beat_t b;
    ok       = 1'b0;
    s_tdata  = d;
    s_tlast  = l;
    s_tdest  = de;
    s_tuser  = u;
    drop     = dr;
    s_tkeep  = 1'($urandom);
    s_tid    = 8'($urandom);
    select   = 2'($urandom);
    s_tvalid = 1'b1;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      ok = (s_tready === 1'b1);
      step();
    end
    s_tvalid = 1'b0;
    if (ok) begin
      if (first && dx) begin
        drops_exp++;
        pulses_exp++;
      end
      if (!dx) begin
        b.d  = d;
        b.l  = l;
        b.de = de;
        b.u  = u;
        expq[rt].push_back(b);
        if (l) frames_exp++;
      end
    end
  endtask

  task automatic send_frame(input int len, input logic [7:0] dest0, input logic drp,
                            input logic [7:0] d0, input bit rnd);
    int         rt;
    bit         dx;
    bit         ok;
    logic [7:0] de;
    logic       dr;
    rt = int'(dest0) % 4;
    dx = drp || (rt >= M);
    for (int i = 0; i < len; i++) begin
      de = (rnd && i != 0) ? 8'($urandom) : dest0;
      dr = (i == 0) ? drp : (rnd ? 1'($urandom) : 1'b0);
      send_beat(rnd ? 8'($urandom) : d0 + 8'(i), i == len - 1, de,
                rnd ? 1'($urandom) : 1'(i % 2), dr, i == 0, rt, dx, 200, ok);
      chk("beat_accepted", 32'(ok), 1);
      if (!ok) return;
      if (rnd && $urandom_range(0, 3) == 0) step();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    s_tvalid = 1'b0;
    while ((expq[0].size() + expq[1].size() + expq[2].size()) != 0 && n < 2000) begin
      step();
      n++;
    end
    chk("drain_done", 32'(expq[0].size() + expq[1].size() + expq[2].size()), 0);
    repeat (2) step();
  endtask

  task automatic chk_stats();
    chk("stat_frames", 32'(stat_frames), sat(frames_exp));
    chk("stat_drops", 32'(stat_drops), sat(drops_exp));
  endtask

  initial begin
    int p0;
    bit ok;
    rst = 1'b1; enable = 1'b1; drop = 1'b0; select = '0;
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = 1'b0; s_tlast = 1'b0;
    s_tid = '0; s_tdest = '0; s_tuser = 1'b0; m_tready = 3'b111;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_tvalid", 32'(m_tvalid), 0);
    chk("reset_frames", 32'(stat_frames), 0);
    chk("reset_drops", 32'(stat_drops), 0);
    chk("reset_pulse", 32'(stat_drop_pulse), 0);
    chk("reset_busy", 32'(stat_busy), 0);
    step();

    // 4-beat frame to lane 2, one cycle latency, back to back.
    send_frame(4, 8'h02, 1'b0, 8'h11, 1'b0);
    @(negedge clk);
    chk("lat_last_beat", 32'(m_tvalid), 32'b100);
    @(negedge clk);
    chk("lat_idle", 32'(m_tvalid), 0);
    step();
    chk_stats();

    // Out-of-range tdest 3 drops the frame; tdest 1 is delivered intact.
    p0 = n_pulse;
    send_frame(3, 8'h03, 1'b0, 8'h21, 1'b0);
    repeat (3) step();
    chk("drop_pulse_once", 32'(n_pulse - p0), 1);
    chk_stats();
    send_frame(2, 8'h01, 1'b0, 8'h31, 1'b0);
    drain();
    chk_stats();

    // Lane 0 stalled: its frame parks in the skid, lane 1 keeps flowing.
    rdy_fixed = 3'b110;
    m_tready  = rdy_fixed;
    send_frame(2, 8'h00, 1'b0, 8'h41, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_beat(8'h51 + 8'(i), i == 2, 8'h01, 1'b0, 1'b0, i == 0, 1, 1'b0, 1, ok);
      chk("lane1_no_stall", 32'(ok), 1);
    end
    chk("lane0_parked", 32'(m_tvalid[0]), 1);
    send_beat(8'h61, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b0, 3, ok);
    chk("lane0_full_blocks", 32'(ok), 0);
    rdy_fixed = 3'b111;
    m_tready  = rdy_fixed;
    send_beat(8'h61, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b0, 5, ok);
    chk("lane0_resumes", 32'(ok), 1);
    drain();
    chk_stats();

    // drop on a single-beat frame, then a normal single-beat frame.
    send_frame(1, 8'h00, 1'b1, 8'h71, 1'b0);
    chk("busy_after_drop", 32'(stat_busy), 0);
    send_frame(1, 8'h01, 1'b0, 8'h72, 1'b0);
    chk("busy_after_single", 32'(stat_busy), 0);
    drain();
    chk_stats();

    // Reset mid-frame with lane 0 skid full.
    rdy_fixed = 3'b110;
    m_tready  = rdy_fixed;
    send_beat(8'h81, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 2, ok);
    send_beat(8'h82, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 2, ok);
    chk("busy_mid_frame", 32'(stat_busy), 1);
    rst = 1'b1;
    for (int k = 0; k < M; k++) expq[k].delete();
    frames_exp = 0;
    drops_exp  = 0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", 32'(m_tvalid), 0);
    chk("rst_busy", 32'(stat_busy), 0);
    step();
    chk_stats();
    send_frame(1, 8'h01, 1'b0, 8'h91, 1'b0);
    drain();
    chk_stats();
    rdy_fixed = 3'b111;

    // Random traffic with random backpressure and enable.
    rdy_rand = 1'b1;
    en_rand  = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      send_frame($urandom_range(1, 16), 8'($urandom), ($urandom_range(0, 9) == 0),
                 8'h00, 1'b1);
      if ((f < 40 && f % 4 == 3) || f % 100 == 99) begin
        drain();
        chk_stats();
      end
    end
    drain();
    chk_stats();
    chk("pulse_total", 32'(n_pulse), 32'(pulses_exp));
    rdy_rand = 1'b0;
    en_rand  = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
